// File: rtl/fp32_pkg.sv
// Shared types and constants for the binary32 add/subtract core.
package fp32_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } fp32_add_state_t;

   localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
   localparam int          FP32_EXP_BIAS = 127;
   localparam int          FP32_EXP_MAX  = 255;

   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;
   localparam int FP32_SIG_W  = 27;

endpackage

// File: rtl/fp32_lzc.sv
// Combinational leading-zero counter over the 28-bit raw sum (28 when all zero).
module fp32_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   // Scan upward so the highest set bit is the last one to set the count.
   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (value[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp32_add_seq.sv
// Multi-cycle binary32 adder/subtractor: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fp32_add_seq
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_invalid,
   output logic        out_overflow
);

   fp32_add_state_t state, state_next;

   logic [31:0] a_q, b_q;
   logic        spec_q, spec_inv_q, big_sign_q, zero_sign_q, eff_sub_q;
   logic [31:0] spec_val_q;
   logic [FP32_EXP_W:0]   exp_q, norm_exp_q;
   logic [FP32_SIG_W-1:0] big_sig_q, small_sig_q, norm_sig_q;
   logic [FP32_SIG_W:0]   sum_q;
   logic        norm_zero_q, norm_sign_q;
   logic [31:0] result_q;
   logic        invalid_q, overflow_q;

   logic [30:0] mag_a, mag_b, mag_big, mag_small;
   logic        swap, sign_big;
   logic [FP32_EXP_W-1:0] exp_diff;
   logic [FP32_SIG_W-1:0] sig_big_w, sig_small_w, small_shifted, lost_mask;
   logic        a_nan, b_nan, a_inf, b_inf, spec_hit, spec_inv;
   logic [31:0] spec_val;

   logic [4:0]  lz_count, norm_shamt;
   logic [FP32_SIG_W-1:0] norm_sig;
   logic [FP32_EXP_W:0]   norm_exp;
   logic        norm_zero, norm_sign;

   logic        round_inc;
   logic [24:0] rounded;
   logic [FP32_EXP_W:0]   round_exp;
   logic [FP32_FRAC_W-1:0] round_frac;
   logic [31:0] round_result;
   logic        round_overflow;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Fixed walk through the pipeline stages, waiting in DONE for the consumer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready     = (state == IDLE);
   assign out_valid    = (state == DONE);
   assign out_result   = result_q;
   assign out_invalid  = invalid_q;
   assign out_overflow = overflow_q;

   // Unpack, flush subnormals, order by magnitude, align the smaller significand and resolve specials.
   always_comb begin
      mag_a       = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
      mag_b       = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
      swap        = (mag_b > mag_a);
      mag_big     = swap ? mag_b : mag_a;
      mag_small   = swap ? mag_a : mag_b;
      sign_big    = swap ? b_q[31] : a_q[31];
      sig_big_w   = {|mag_big[30:23], mag_big[22:0], 3'b000};
      sig_small_w = {|mag_small[30:23], mag_small[22:0], 3'b000};
      exp_diff    = mag_big[30:23] - mag_small[30:23];
      lost_mask   = '0;
      if (exp_diff >= 8'd27) begin
         small_shifted = {26'd0, |sig_small_w};
      end else begin
         lost_mask        = ~({FP32_SIG_W{1'b1}} << exp_diff);
         small_shifted    = sig_small_w >> exp_diff;
         small_shifted[0] = small_shifted[0] | (|(sig_small_w & lost_mask));
      end
      a_nan    = (&a_q[30:23]) && (|a_q[22:0]);
      b_nan    = (&b_q[30:23]) && (|b_q[22:0]);
      a_inf    = (&a_q[30:23]) && !(|a_q[22:0]);
      b_inf    = (&b_q[30:23]) && !(|b_q[22:0]);
      spec_hit = a_nan || b_nan || a_inf || b_inf;
      spec_inv = a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]));
      if (spec_inv)   spec_val = FP32_QNAN;
      else if (a_inf) spec_val = a_q;
      else            spec_val = b_q;
   end

   fp32_lzc u_lzc (
      .value (sum_q),
      .count (lz_count)
   );

   // Renormalise the raw sum: carry shifts right, otherwise shift left unless that would underflow.
   always_comb begin
      norm_shamt = lz_count - 5'd1;
      norm_sig   = '0;
      norm_exp   = exp_q;
      norm_zero  = 1'b0;
      norm_sign  = big_sign_q;
      if (sum_q[FP32_SIG_W]) begin
         norm_sig = {sum_q[27:2], sum_q[1] | sum_q[0]};
         norm_exp = exp_q + 9'd1;
      end else if (sum_q == '0) begin
         norm_zero = 1'b1;
         norm_sign = zero_sign_q;
      end else if ({4'd0, norm_shamt} >= exp_q) begin
         norm_zero = 1'b1;
      end else begin
         norm_sig = sum_q[26:0] << norm_shamt;
         norm_exp = exp_q - {4'd0, norm_shamt};
      end
   end

   // Round to nearest even and pack, letting specials override the arithmetic result.
   always_comb begin
      round_inc      = norm_sig_q[2] && (norm_sig_q[1] || norm_sig_q[0] || norm_sig_q[3]);
      rounded        = {1'b0, norm_sig_q[26:3]} + {24'd0, round_inc};
      round_exp      = norm_exp_q + {8'd0, rounded[24]};
      round_frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
      round_overflow = 1'b0;
      if (spec_q) begin
         round_result = spec_val_q;
      end else if (norm_zero_q) begin
         round_result = {norm_sign_q, 31'd0};
      end else if (round_exp >= 9'(FP32_EXP_MAX)) begin
         round_result   = {norm_sign_q, 8'hFF, 23'd0};
         round_overflow = 1'b1;
      end else begin
         round_result = {norm_sign_q, round_exp[7:0], round_frac};
      end
   end

   // Datapath registers advance one stage per state; subtraction becomes a sign flip on b.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_q <= in_a;
               b_q <= {in_b[31] ^ in_op, in_b[30:0]};
            end
         end
         ALIGN: begin
            spec_q      <= spec_hit;
            spec_inv_q  <= spec_inv;
            spec_val_q  <= spec_val;
            big_sign_q  <= sign_big;
            zero_sign_q <= a_q[31] & b_q[31];
            eff_sub_q   <= a_q[31] ^ b_q[31];
            exp_q       <= {1'b0, mag_big[30:23]};
            big_sig_q   <= sig_big_w;
            small_sig_q <= small_shifted;
         end
         ADD: begin
            sum_q <= eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                               : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
         end
         NORM: begin
            norm_sig_q  <= norm_sig;
            norm_exp_q  <= norm_exp;
            norm_zero_q <= norm_zero;
            norm_sign_q <= norm_sign;
         end
         default: ;
      endcase
   end

   // Result and flags are captured once in ROUND and held through DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q   <= 32'd0;
         invalid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else if (state == ROUND) begin
         result_q   <= round_result;
         invalid_q  <= spec_q && spec_inv_q;
         overflow_q <= !spec_q && round_overflow;
      end
   end

endmodule

// File: tb/tb_fp32_add_seq.sv
// Self-checking bench for fp32_add_seq: directed cases plus randomized ops against an exact-arithmetic model.
module tb_fp32_add_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_invalid;
   logic        out_overflow;

   int n_compared   = 0;
   int n_mismatched = 0;

   fp32_add_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_op        (in_op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_invalid  (out_invalid),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   // Reference: exact sum as a wide integer scaled by 2^149, then RNE with flush-to-zero.
   function automatic void ref_add(input logic [31:0] a, input logic [31:0] b_raw, input logic op,
                                   output logic [31:0] res, output logic inv, output logic ovf);
      logic [31:0]  b;
      logic [299:0] xa, xb, mag, low_mask;
      logic         sgn, g, rest, a_inf, b_inf;
      logic [24:0]  sig;
      int           p, be;
      b   = {b_raw[31] ^ op, b_raw[30:0]};
      res = 32'd0;
      inv = 1'b0;
      ovf = 1'b0;
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
         res = 32'h7FC00000; inv = 1'b1; return;
      end
      if (a_inf && b_inf && a[31] != b[31]) begin
         res = 32'h7FC00000; inv = 1'b1; return;
      end
      if (a_inf) begin res = a; return; end
      if (b_inf) begin res = b; return; end
      xa = '0;
      xb = '0;
      if (a[30:23] != 8'd0) xa = {276'd0, 1'b1, a[22:0]} << (a[30:23] - 1);
      if (b[30:23] != 8'd0) xb = {276'd0, 1'b1, b[22:0]} << (b[30:23] - 1);
      if (a[31] == b[31])  begin mag = xa + xb; sgn = a[31]; end
      else if (xa >= xb)   begin mag = xa - xb; sgn = a[31]; end
      else                 begin mag = xb - xa; sgn = b[31]; end
      if (mag == '0) begin res = {a[31] & b[31], 31'd0}; return; end
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      be = p - 22;
      if (be < 1) begin res = {sgn, 31'd0}; return; end
      sig  = 25'(mag >> (p - 23));
      g    = 1'b0;
      rest = 1'b0;
      if (p >= 24) begin
         g        = mag[p - 24];
         low_mask = (300'd1 << (p - 24)) - 300'd1;
         rest     = |(mag & low_mask);
      end
      if (g && (rest || sig[0])) sig = sig + 25'd1;
      if (sig[24]) begin sig = sig >> 1; be = be + 1; end
      if (be >= 255) begin res = {sgn, 8'hFF, 23'd0}; ovf = 1'b1; return; end
      res = {sgn, 8'(be), sig[22:0]};
   endfunction

   function automatic logic [31:0] gen_operand(input int base_exp);
      int          kind;
      int          e;
      logic [31:0] v;
      kind = $urandom_range(0, 24);
      v    = $urandom;
      if (kind == 0) begin
         v[30:23] = 8'd0;
      end else if (kind == 1) begin
         v[30:23] = 8'hFF; v[22:0] = 23'd0;
      end else if (kind == 2) begin
         v[30:23] = 8'hFF; v[22] = 1'b1;
      end else begin
         e = base_exp + int'($urandom_range(0, 60)) - 30;
         if (e < 1)   e = 1;
         if (e > 254) e = 254;
         v[30:23] = 8'(e);
      end
      return v;
   endfunction

   // Issue one op with out_ready high and check latency, result, flags and return to idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] exp_res, input logic exp_inv, input logic exp_ovf,
                         input string tag);
      int edges;
      @(negedge clk);
      n_compared++;
      if (in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL %s ready_before_accept: got %b want 1", tag, in_ready);
      end
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 1'($urandom);
      edges = 0;
      while (out_valid !== 1'b1 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      n_compared++;
      if (edges != 4) begin
         n_mismatched++;
         $display("[TB] FAIL %s latency: got %0d edges want 4", tag, edges);
      end
      n_compared++;
      if (out_result !== exp_res) begin
         n_mismatched++;
         $display("[TB] FAIL %s result: a=%h b=%h op=%b got %h want %h", tag, a, b, op, out_result, exp_res);
      end
      n_compared++;
      if (out_invalid !== exp_inv || out_overflow !== exp_ovf) begin
         n_mismatched++;
         $display("[TB] FAIL %s flags: a=%h b=%h op=%b got inv=%b ovf=%b want inv=%b ovf=%b",
                  tag, a, b, op, out_invalid, out_overflow, exp_inv, exp_ovf);
      end
      n_compared++;
      if (in_ready !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL %s busy_ready: got %b want 0", tag, in_ready);
      end
      @(posedge clk); #1;
      n_compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL %s handoff: got ready=%b valid=%b want ready=1 valid=0", tag, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
          out_invalid !== 1'b0 || out_overflow !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_state: got ready=%b valid=%b result=%h inv=%b ovf=%b want 1 0 00000000 0 0",
                  in_ready, out_valid, out_result, out_invalid, out_overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, "one_plus_two");
      run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, "three_minus_one");
   endtask

   task automatic test_zero();
      run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, "one_minus_one");
      run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, "negzero_sum");
      run_op(32'h80400000, 32'h80000001, 1'b0, 32'h80000000, 1'b0, 1'b0, "subnormal_flush");
      run_op(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0, "underflow_flush");
   endtask

   task automatic test_rounding();
      run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "tie_even");
      run_op(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0, "above_tie");
      run_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, "tie_odd");
   endtask

   task automatic test_specials();
      run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, "inf_minus_inf");
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, "overflow");
      run_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, "nan_input");
      run_op(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, "inf_passthrough");
   endtask

   task automatic test_random();
      logic [31:0] a, b, exp_res;
      logic        op, exp_inv, exp_ovf;
      int          base;
      for (int n = 0; n < 150; n++) begin
         base = $urandom_range(1, 254);
         a    = gen_operand(base);
         b    = gen_operand(base);
         op   = 1'($urandom);
         if ($urandom_range(0, 3) == 0) b = a ^ 32'($urandom_range(0, 255));
         ref_add(a, b, op, exp_res, exp_inv, exp_ovf);
         run_op(a, b, op, exp_res, exp_inv, exp_ovf, "random");
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      @(negedge clk);
      in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_a = 32'h12345678; in_b = 32'h7F800000; in_op = 1'b1;
      edges = 0;
      while (out_valid !== 1'b1 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      for (int i = 0; i < 10; i++) begin
         n_compared++;
         if (out_valid !== 1'b1 || out_result !== 32'h40400000 || in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_stable: cycle %0d got valid=%b result=%h ready=%b want 1 40400000 0",
                     i, out_valid, out_result, in_ready);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
      end
      run_op(32'hC0A00000, 32'h40200000, 1'b0, 32'hC0200000, 1'b0, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_a = 32'h40400000; in_b = 32'h3F800000; in_op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
          out_invalid !== 1'b0 || out_overflow !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL mid_reset: got ready=%b valid=%b result=%h inv=%b ovf=%b want 1 0 00000000 0 0",
                  in_ready, out_valid, out_result, out_invalid, out_overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL discarded_op: got valid=%b want 0", out_valid);
      end
      run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, "after_reset");
   endtask

   initial begin
      $display("[TB] starting fp32_add_seq bench");
      test_reset();
      test_basic();
      test_zero();
      test_rounding();
      test_specials();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
